// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

   typedef enum logic [2:0] {
      LEN  = 3'd0,
      DATA = 3'd1,
      ACK  = 3'd2,
      NAK  = 3'd3,
      RUN  = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [7:0]  ACK_BYTE_DEF   = 8'hAA;
   localparam logic [7:0]  NAK_BYTE_DEF   = 8'hEE;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; strobes on the last lane.
module byte_packer
   import boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_valid,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word_c,
   output logic              o_word_valid_c
);

   logic [LANE_W-1:0] r_idx;
   logic [WORD_W-1:0] r_word;

   // Merge the incoming byte into its lane so the full word is visible on the 4th strobe.
   always_comb begin
      o_word_c                    = r_word;
      o_word_c[{r_idx, 3'b000} +: 8] = i_byte;
      o_word_valid_c              = i_valid && (r_idx == LANE_W'(BYTES_PER_WORD - 1));
   end

   // Lane counter wraps 3->0; clear drops any partially assembled word.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_valid) begin
         r_idx  <= LANE_W'(r_idx + 1'b1);
         r_word <= o_word_c;
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed image over UART, writes it to BRAM, then releases the core.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
   parameter logic [7:0]  NAK_BYTE = NAK_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [32:0] CAP   = 33'(1) << ADDR_W;

   state_t             r_state;
   logic [CNT_W-1:0]   r_wcnt;
   logic [CNT_W-1:0]   r_len;

   logic               w_loading;
   logic               w_pk_valid;
   logic [WORD_W-1:0]  w_word;
   logic               w_word_valid;
   logic               w_len_zero;
   logic               w_len_big;
   logic               w_len_to_data;
   logic               w_last_word;

   // Byte strobes only feed the packer while the image is being received.
   assign w_loading     = (r_state == LEN) || (r_state == DATA);
   assign w_pk_valid    = rx_valid && w_loading;
   assign w_len_zero    = (w_word == '0);
   assign w_len_big     = ({1'b0, w_word} > CAP);
   assign w_len_to_data = (r_state == LEN) && w_word_valid && !w_len_zero && !w_len_big;
   assign w_last_word   = (CNT_W'(r_wcnt + 1'b1) == r_len);

   byte_packer u_packer (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (w_len_to_data),
      .i_valid        (w_pk_valid),
      .i_byte         (rx_data),
      .o_word_c       (w_word),
      .o_word_valid_c (w_word_valid)
   );

   // Load sequencer: length, data words, handshake byte, then terminal RUN/ERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= LEN;
         r_wcnt    <= '0;
         r_len     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         core_hold <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         tx_start <= 1'b0;
         unique case (r_state)
            LEN: begin
               if (w_word_valid) begin
                  r_wcnt <= '0;
                  if (w_len_zero) begin
                     r_state <= ACK;
                  end else if (w_len_big) begin
                     r_state <= NAK;
                  end else begin
                     r_len   <= CNT_W'(w_word);
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_word_valid) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= r_wcnt[ADDR_W-1:0];
                  mem_wdata <= w_word;
                  r_wcnt    <= CNT_W'(r_wcnt + 1'b1);
                  if (w_last_word) begin
                     r_state <= ACK;
                  end
               end
            end
            ACK: begin
               if (!tx_busy) begin
                  tx_start  <= 1'b1;
                  tx_data   <= ACK_BYTE;
                  core_hold <= 1'b0;
                  load_done <= 1'b1;
                  r_state   <= RUN;
               end
            end
            NAK: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= NAK_BYTE;
                  load_err <= 1'b1;
                  r_state  <= ERR;
               end
            end
            RUN, ERR: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= LEN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: byte-stream model of the boot protocol plus directed loads.
module tb_uart_boot_loader;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_hold;
   logic          load_done;
   logic          load_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;

   uart_boot_loader #(.ADDR_W(AW), .ACK_BYTE(8'hAA), .NAK_BYTE(8'hEE)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_hold (core_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- protocol model (byte stream level) ----------------
   logic [7:0]    mb [0:127];
   int unsigned   m_cnt;
   logic [31:0]   m_n;
   bit            m_loading;
   bit            m_pending;
   bit            m_is_ack;
   int            k;
   logic          e_we, e_ts, e_hold, e_done, e_err;
   logic [AW-1:0] e_addr;
   logic [31:0]   e_wd;
   logic [7:0]    e_txd;

   task automatic model_finish(input bit ack);
      m_loading = 1'b0;
      m_pending = 1'b1;
      m_is_ack  = ack;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0; m_loading = 1'b1; m_pending = 1'b0; m_is_ack = 1'b0; m_n = '0;
         e_we = 1'b0; e_addr = '0; e_wd = '0; e_ts = 1'b0; e_txd = '0;
         e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0;
      end else begin
         e_we = 1'b0;
         e_ts = 1'b0;
         if (m_pending) begin
            if (!tx_busy) begin
               e_ts      = 1'b1;
               e_txd     = m_is_ack ? 8'hAA : 8'hEE;
               m_pending = 1'b0;
               if (m_is_ack) begin
                  e_hold = 1'b0;
                  e_done = 1'b1;
               end else begin
                  e_err = 1'b1;
               end
            end
         end else if (m_loading && rx_valid) begin
            mb[m_cnt] = rx_data;
            m_cnt++;
            if (m_cnt == 4) begin
               m_n = {mb[3], mb[2], mb[1], mb[0]};
               if (m_n == 0) model_finish(1'b1);
               else if (64'(m_n) > (64'd1 << AW)) model_finish(1'b0);
            end else if (m_cnt > 4 && (m_cnt % 4) == 0) begin
               k      = int'((m_cnt - 8) / 4);
               e_we   = 1'b1;
               e_addr = AW'(k);
               e_wd   = {mb[m_cnt-1], mb[m_cnt-2], mb[m_cnt-3], mb[m_cnt-4]};
               if (32'(k + 1) == m_n) model_finish(1'b1);
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("mem_we",    32'(mem_we),    32'(e_we));
         check("mem_addr",  32'(mem_addr),  32'(e_addr));
         check("mem_wdata", mem_wdata,      e_wd);
         check("tx_start",  32'(tx_start),  32'(e_ts));
         check("tx_data",   32'(tx_data),   32'(e_txd));
         check("core_hold", 32'(core_hold), 32'(e_hold));
         check("load_done", 32'(load_done), 32'(e_done));
         check("load_err",  32'(load_err),  32'(e_err));
      end
   end

   // ---------------- event monitor for literal checks ----------------
   logic [AW-1:0] wq_a [$];
   logic [31:0]   wq_d [$];
   logic [7:0]    tq [$];
   int            tq_cyc [$];

   always @(posedge clk) begin
      #1;
      if (mem_we) begin
         wq_a.push_back(mem_addr);
         wq_d.push_back(mem_wdata);
      end
      if (tx_start) begin
         tq.push_back(tx_data);
         tq_cyc.push_back(cyc);
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wq_a.delete(); wq_d.delete(); tq.delete(); tq_cyc.delete();
      @(negedge clk);
   endtask

   task automatic wait_tx(input int budget);
      int n = 0;
      while (tq.size() == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("tx_wait_timeout", 32'(tq.size() > 0), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   int c0;

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_core_hold", 32'(core_hold), 32'd1);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_err",  32'(load_err),  32'd0);
      check("rst_tx_start",  32'(tx_start),  32'd0);
      cmp_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);

      // N=2 load
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'hDEAD_BEEF);
      wait_tx(20);
      check("n2_writes", 32'(wq_a.size()), 32'd2);
      if (wq_a.size() == 2) begin
         check("n2_addr0", 32'(wq_a[0]), 32'd0);
         check("n2_data0", wq_d[0],      32'h0000_0013);
         check("n2_addr1", 32'(wq_a[1]), 32'd1);
         check("n2_data1", wq_d[1],      32'hDEAD_BEEF);
      end
      check("n2_tx_byte",   32'(tq[0]),     32'h0000_00AA);
      check("n2_core_hold", 32'(core_hold), 32'd0);
      check("n2_load_done", 32'(load_done), 32'd1);

      // Random bytes after RUN are ignored
      for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
      check("run_no_writes", 32'(wq_a.size()), 32'd2);
      check("run_one_tx",    32'(tq.size()),   32'd1);
      check("run_core_hold", 32'(core_hold),   32'd0);

      // N=0
      do_reset();
      send_word(32'd0);
      wait_tx(20);
      check("n0_writes",    32'(wq_a.size()), 32'd0);
      check("n0_tx_byte",   32'(tq[0]),       32'h0000_00AA);
      check("n0_core_hold", 32'(core_hold),   32'd0);

      // N=17 oversize
      do_reset();
      send_word(32'd17);
      wait_tx(20);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i));
      check("nak_writes",    32'(wq_a.size()), 32'd0);
      check("nak_tx_count",  32'(tq.size()),   32'd1);
      check("nak_tx_byte",   32'(tq[0]),       32'h0000_00EE);
      check("nak_load_err",  32'(load_err),    32'd1);
      check("nak_core_hold", 32'(core_hold),   32'd1);
      check("nak_load_done", 32'(load_done),   32'd0);

      // N=16 exactly fills the address space
      do_reset();
      send_word(32'd16);
      for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 + 32'(i));
      wait_tx(20);
      check("full_writes", 32'(wq_a.size()), 32'd16);
      if (wq_a.size() == 16) begin
         check("full_last_addr", 32'(wq_a[15]), 32'd15);
         check("full_last_data", wq_d[15],      32'hC0DE_000F);
      end
      check("full_tx_byte", 32'(tq[0]), 32'h0000_00AA);

      // tx_busy held at completion
      do_reset();
      tx_busy = 1'b1;
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
      repeat (50) @(negedge clk);
      check("busy_no_tx", 32'(tq.size()), 32'd0);
      c0      = cyc;
      tx_busy = 1'b0;
      wait_tx(20);
      check("busy_tx_count", 32'(tq.size()), 32'd1);
      if (tq_cyc.size() > 0) check("busy_tx_cycle", 32'(tq_cyc[0]), 32'(c0 + 1));

      // Reset mid-load, then fresh N=1 load
      do_reset();
      send_word(32'd1);
      send_byte(8'hAB);
      send_byte(8'hCD);
      do_reset();
      send_word(32'd1);
      send_word(32'h1234_5678);
      wait_tx(20);
      check("rst_mid_writes", 32'(wq_a.size()), 32'd1);
      if (wq_a.size() == 1) begin
         check("rst_mid_addr", 32'(wq_a[0]), 32'd0);
         check("rst_mid_data", wq_d[0],      32'h1234_5678);
      end
      check("rst_mid_tx", 32'(tq[0]), 32'h0000_00AA);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Upstream stage of the core/BRAM pair. Takes bytes from the UART receiver and writes a length-prefixed program image into instruction/data BRAM through the BRAM write port. Holds the riscv core in reset until the image is complete, then sends an ack byte to the host through the UART transmitter. Owns the BRAM write port only while loading; after release, the core drives it through the top-level mux.

Parameters:
ADDR_W, 20, BRAM word-address width (matches BRAM addra)
ACK_BYTE, 8'hAA, byte sent to host after a successful load
NAK_BYTE, 8'hEE, byte sent to host when the length exceeds capacity

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  one-cycle strobe; rx_data valid
tx_data  out  8  byte to uart_tx
tx_start  out  1  one-cycle request to uart_tx
tx_busy  in  1  uart_tx busy; tx_start is legal only when low
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM word address
mem_wdata  out  32  BRAM write data
core_hold  out  1  high keeps the core in reset; top drives core rstn = ~core_hold
load_done  out  1  level; high after a successful load
load_err  out  1  level; high after an oversize length

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, tx_start=0, tx_data=0, core_hold=1, load_done=0, load_err=0; state=LEN; byte and word counters=0.
- Protocol: 4 bytes little-endian word count N, then N words of 4 bytes each, little-endian.
- Byte packing: a 2-bit byte index selects the lane (byte i goes to bits [8i+7:8i]). The index wraps 3->0.
- LEN state:
  - Collect 4 bytes into N.
  - On the 4th byte: if N==0, go to ACK. If N > 2**ADDR_W, go to NAK. Otherwise go to DATA.
- DATA state:
  - On the 4th byte of word k (strobe at cycle t): at t+1, mem_we=1 for exactly one cycle, mem_addr=k, mem_wdata=assembled word.
  - After word N-1 is written, go to ACK.
  - The word counter is ADDR_W+1 bits wide so N=2**ADDR_W does not wrap.
- ACK state:
  - Wait for tx_busy==0.
  - Then pulse tx_start for 1 cycle with tx_data=ACK_BYTE, and go to RUN.
- RUN state: core_hold=0, load_done=1. Terminal until rst.
- NAK state:
  - Wait for tx_busy==0, pulse tx_start with NAK_BYTE, and go to ERR.
  - ERR: load_err=1, core_hold stays 1. Terminal until rst.
- rx_valid in ACK, NAK, RUN and ERR is ignored; no BRAM write, no state change.
- rx_valid on the same cycle as a pending tx wait has no effect on the transmit.
- Only one tx_start is ever issued per load.
- mem_we is 0 in every state except the single write cycle.
- rst mid-load: return to LEN with all counters cleared and core_hold=1. BRAM contents already written are kept, not cleared. A partial word is discarded.
- No timeout. A stalled host leaves the block in LEN or DATA indefinitely.

Decomposition:
- Package boot_pkg:
  - state enum {LEN, DATA, ACK, NAK, RUN, ERR}
  - ACK/NAK byte constants
  - localparam BYTES_PER_WORD=4
- One sub-module, byte_packer: 2-bit lane counter plus a 32-bit shift/merge register. Outputs word and a word_valid strobe. Cleared by rst and by the FSM on the LEN->DATA transition.

Test Plan:
- Load N=2, words 32'h00000013 and 32'hDEADBEEF (bytes 02 00 00 00 13 00 00 00 EF BE AD DE):
  - mem_we pulses twice: addr 0 data 32'h13, then addr 1 data 32'hDEADBEEF, each one cycle after the 4th byte strobe.
  - Then tx_start with 8'hAA; core_hold falls and load_done=1.
- N=0 (00 00 00 00): no mem_we; ack 8'hAA sent; core released.
- N = 2**ADDR_W+1 (with ADDR_W=4, N=17): no mem_we; tx 8'hEE; load_err=1; core_hold stays 1; further bytes ignored.
- Hold tx_busy=1 for 50 cycles at load completion: tx_start stays 0 until the cycle after tx_busy falls, then pulses exactly once.
- Assert rst after 6 bytes of a load, then send a fresh N=1 load with word 32'h12345678: the single write goes to addr 0 with 32'h12345678, and no stale bytes are merged in.
- After RUN, inject 10 random rx_valid bytes: mem_we stays 0, tx_start stays 0, core_hold stays 0.
